// File: rtl/interfaz_bus_memoria_pkg.sv
// Shared definitions for the memory bus interface: bus FSM states and
// Control word bit positions.
package paquete_cpu;

  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    LECTURA   = 2'd1,
    ESCRITURA = 2'd2,
    COMPLETO  = 2'd3
  } estado_bus_e;

  localparam int CTRL_LEE       = 5;
  localparam int CTRL_RESERVADO = 4;
  localparam int CTRL_ESCRIBE   = 3;
  localparam int CTRL_DIR_PC    = 2;
  localparam int CTRL_DIR_AR    = 1;
  localparam int CTRL_DATO      = 0;

  localparam logic [5:0] CMD_FETCH = 6'b100100;

endpackage

// File: rtl/interfaz_bus_memoria_if.sv
// Memory-side request/acknowledge bus; master is the bus interface,
// slave is the external instruction/data memory.
interface interfaz_bus_memoria_if #(
  parameter int ANCHO_DATOS = 16,
  parameter int ANCHO_DIR   = 16
);
  logic [ANCHO_DIR-1:0]   MemDir;
  logic [ANCHO_DATOS-1:0] MemDatoSal;
  logic [ANCHO_DATOS-1:0] MemDatoEnt;
  logic                   MemLee;
  logic                   MemEscribe;
  logic                   MemAck;

  modport master (
    output MemDir, MemDatoSal, MemLee, MemEscribe,
    input  MemDatoEnt, MemAck
  );

  modport slave (
    input  MemDir, MemDatoSal, MemLee, MemEscribe,
    output MemDatoEnt, MemAck
  );
endinterface

// File: rtl/interfaz_bus_memoria_contador_limite.sv
// Wait-cycle counter: clear, count-enable and a flag raised on the enabled
// cycle whose increment would reach LIMITE.
module contador_limite #(
  parameter int LIMITE = 255
) (
  input  logic clk,
  input  logic srst,
  input  logic clr_i,
  input  logic en_i,
  output logic fin_o
);
  localparam int ANCHO = $clog2(LIMITE + 1);

  logic [ANCHO-1:0] cuenta_q, cuenta_d;

  assign fin_o = en_i && (cuenta_q == ANCHO'(LIMITE - 1));

  always_comb begin
    cuenta_d = cuenta_q;
    if (clr_i) begin
      cuenta_d = '0;
    end else if (en_i && !fin_o) begin
      cuenta_d = cuenta_q + ANCHO'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end
endmodule

// File: rtl/interfaz_bus_memoria.sv
// 4-phase request/acknowledge memory bus interface for the control unit.
// Define TIEMPO_LIMITE_EN to abort transactions after CICLOS_LIMITE wait cycles.
module interfaz_bus_memoria
  import paquete_cpu::*;
#(
  parameter int ANCHO_DATOS   = 16,
  parameter int ANCHO_DIR     = 16,
  parameter int CICLOS_LIMITE = 255
) (
  input  logic                   Reloj,
  input  logic                   Reiniciar,
  input  logic [5:0]             Control,
  input  logic [ANCHO_DIR-1:0]   PC,
  input  logic [ANCHO_DIR-1:0]   AR,
  input  logic [ANCHO_DATOS-1:0] DatoEscritura,
  output logic [ANCHO_DATOS-1:0] DatoLeido,
  output logic                   Listo,
  output logic                   Ocupado,
  output logic                   ErrorProtocolo,
  interfaz_bus_memoria_if.master mem
);
  estado_bus_e            estado_q, estado_d;
  logic [ANCHO_DIR-1:0]   dir_q, dir_d;
  logic [ANCHO_DATOS-1:0] dato_sal_q, dato_sal_d;
  logic [ANCHO_DATOS-1:0] dato_leido_q, dato_leido_d;
  logic                   listo_q, listo_d;
  logic                   error_q, error_d;
  logic                   pide_lee, pide_escribe, expira;
  logic [ANCHO_DIR-1:0]   dir_sel;
  logic                   unused_reservado;

  assign unused_reservado = Control[CTRL_RESERVADO];
  assign pide_lee         = (Control[CTRL_LEE] == 1'b1);
  assign pide_escribe     = (Control[CTRL_ESCRIBE] == 1'b1);
  // PC wins over AR when both address sources are requested.
  assign dir_sel = (Control[CTRL_DIR_PC] == 1'b1) ? PC :
                   (Control[CTRL_DIR_AR] == 1'b1) ? AR : '0;

`ifdef TIEMPO_LIMITE_EN
  logic en_espera;
  assign en_espera = (estado_q == LECTURA) || (estado_q == ESCRITURA);

  contador_limite #(
    .LIMITE(CICLOS_LIMITE)
  ) u_contador (
    .clk  (Reloj),
    .srst (Reiniciar),
    .clr_i(!en_espera),
    .en_i (en_espera && !mem.MemAck),
    .fin_o(expira)
  );
`else
  localparam int unused_ciclos_limite = CICLOS_LIMITE;
  assign expira = 1'b0;
`endif

  always_comb begin
    estado_d     = estado_q;
    dir_d        = dir_q;
    dato_sal_d   = dato_sal_q;
    dato_leido_d = dato_leido_q;
    listo_d      = 1'b0;
    error_d      = 1'b0;
    case (estado_q)
      REPOSO: begin
        if (pide_lee && pide_escribe) begin
          error_d = 1'b1;
        end else if (pide_lee || pide_escribe) begin
          dir_d = dir_sel;
          if (pide_escribe && Control[CTRL_DATO] == 1'b1) begin
            dato_sal_d = DatoEscritura;
          end
          estado_d = pide_lee ? LECTURA : ESCRITURA;
        end
      end
      LECTURA, ESCRITURA: begin
        if (mem.MemAck) begin
          if (estado_q == LECTURA) begin
            dato_leido_d = mem.MemDatoEnt;
          end
          listo_d  = 1'b1;
          estado_d = COMPLETO;
        end else if (expira) begin
          error_d  = 1'b1;
          estado_d = REPOSO;
        end
      end
      // Hold until the memory returns its acknowledge to zero.
      COMPLETO: begin
        if (!mem.MemAck) begin
          estado_d = REPOSO;
        end
      end
      default: estado_d = REPOSO;
    endcase
  end

  always_ff @(posedge Reloj) begin
    if (Reiniciar) begin
      estado_q     <= REPOSO;
      dir_q        <= '0;
      dato_sal_q   <= '0;
      dato_leido_q <= '0;
      listo_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      dir_q        <= dir_d;
      dato_sal_q   <= dato_sal_d;
      dato_leido_q <= dato_leido_d;
      listo_q      <= listo_d;
      error_q      <= error_d;
    end
  end

  assign mem.MemDir     = dir_q;
  assign mem.MemDatoSal = dato_sal_q;
  assign mem.MemLee     = (estado_q == LECTURA);
  assign mem.MemEscribe = (estado_q == ESCRITURA);
  assign DatoLeido      = dato_leido_q;
  assign Listo          = listo_q;
  assign ErrorProtocolo = error_q;
  assign Ocupado        = (estado_q != REPOSO);
endmodule

// File: tb/tb_interfaz_bus_memoria.sv
// Scoreboard bench for interfaz_bus_memoria: directed scenarios plus random
// commands against a wait-state memory and a transaction-level model.
module tb_interfaz_bus_memoria;
  import paquete_cpu::*;

  logic        Reloj = 1'b0;
  logic        Reiniciar = 1'b0;
  logic [5:0]  Control = '0;
  logic [15:0] PC = '0, AR = '0, DatoEscritura = '0;
  logic [15:0] DatoLeido;
  logic        Listo, Ocupado, ErrorProtocolo;

  interfaz_bus_memoria_if #(.ANCHO_DATOS(16), .ANCHO_DIR(16)) mem_bus ();

  interfaz_bus_memoria #(
    .ANCHO_DATOS(16), .ANCHO_DIR(16), .CICLOS_LIMITE(255)
  ) dut (
    .Reloj(Reloj), .Reiniciar(Reiniciar), .Control(Control),
    .PC(PC), .AR(AR), .DatoEscritura(DatoEscritura),
    .DatoLeido(DatoLeido), .Listo(Listo), .Ocupado(Ocupado),
    .ErrorProtocolo(ErrorProtocolo), .mem(mem_bus)
  );

  always #5 Reloj = ~Reloj;

  // Memory with programmable wait states, optional forced acknowledge.
  logic [15:0] mem_arr [0:65535];
  logic [15:0] ref_mem [0:65535];
  int   nwait = 0;
  int   wcnt = 0;
  logic hold_ack = 1'b0;
  wire  req = mem_bus.MemLee | mem_bus.MemEscribe;
  assign mem_bus.MemAck     = (req && (wcnt >= nwait)) || hold_ack;
  assign mem_bus.MemDatoEnt = mem_arr[mem_bus.MemDir];

  always @(posedge Reloj) begin
    wcnt <= req ? wcnt + 1 : 0;
    if (mem_bus.MemEscribe && mem_bus.MemAck) mem_arr[mem_bus.MemDir] <= mem_bus.MemDatoSal;
  end

  int n_checks = 0;
  int n_pass = 0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endfunction

  // Reference model: kind 1=read, 2=write, 3=illegal.
  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;
  exp_t        sb[$];
  logic [15:0] m_dato_sal = '0;

  task automatic model_push(input logic [5:0] c, input logic [15:0] pc, ar, dw);
    exp_t e;
    logic [15:0] a;
    a = c[2] ? pc : (c[1] ? ar : 16'h0000);
    e.addr = a;
    e.data = '0;
    if (c[5] && c[3]) begin
      e.kind = 3;
      sb.push_back(e);
    end else if (c[5]) begin
      e.kind = 1;
      e.data = ref_mem[a];
      sb.push_back(e);
    end else if (c[3]) begin
      if (c[0]) m_dato_sal = dw;
      ref_mem[a] = m_dato_sal;
      e.kind = 2;
      e.data = m_dato_sal;
      sb.push_back(e);
    end
  endtask

  // Monitor: observes handshakes and completion/error pulses, pops the scoreboard.
  logic [15:0] obs_addr, obs_dat;
  logic        obs_wr;
  logic        obs_valid = 1'b0;

  always @(negedge Reloj) begin
    if (!Reiniciar) begin
      if (req && mem_bus.MemAck) begin
        obs_addr  = mem_bus.MemDir;
        obs_dat   = mem_bus.MemDatoSal;
        obs_wr    = mem_bus.MemEscribe;
        obs_valid = 1'b1;
        chk("req_exclusive", {31'b0, mem_bus.MemLee & mem_bus.MemEscribe}, 32'd0);
      end
      if (Listo === 1'b1) begin
        chk("listo_expected", {31'b0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("handshake_seen", {31'b0, obs_valid}, 32'd1);
          chk("tx_kind", obs_wr ? 32'd2 : 32'd1, e.kind);
          chk("tx_addr", {16'b0, obs_addr}, {16'b0, e.addr});
          if (e.kind == 1) chk("rd_data", {16'b0, DatoLeido}, {16'b0, e.data});
          else             chk("wr_data", {16'b0, obs_dat}, {16'b0, e.data});
          $display("tx kind=%0d addr=%h data=%h", e.kind, e.addr, e.data);
        end
        obs_valid = 1'b0;
      end
      if (ErrorProtocolo === 1'b1) begin
        chk("err_expected", {31'b0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("err_kind", 32'd3, e.kind);
          chk("err_idle", {31'b0, Ocupado | req}, 32'd0);
          $display("tx kind=3 illegal command rejected");
        end
      end
    end
  end

  task automatic do_reset();
    Reiniciar = 1'b1;
    repeat (2) @(posedge Reloj);
    #1;
    Reiniciar  = 1'b0;
    sb.delete();
    m_dato_sal = '0;
    obs_valid  = 1'b0;
  endtask

  // Issue one command while idle, then follow it until the bus is idle again.
  task automatic run_cmd(input logic [5:0] c, input logic [15:0] pc, ar, dw,
                         output int lee_n, esc_n, listo_n, listo_at, err_n, busy_n);
    logic done;
    lee_n = 0; esc_n = 0; listo_n = 0; listo_at = -1; err_n = 0; busy_n = 0;
    done = 1'b0;
    Control = c; PC = pc; AR = ar; DatoEscritura = dw;
    model_push(c, pc, ar, dw);
    @(posedge Reloj);
    #1 Control = '0;
    for (int k = 1; k <= 60 && !done; k++) begin
      @(negedge Reloj);
      lee_n   += int'(mem_bus.MemLee);
      esc_n   += int'(mem_bus.MemEscribe);
      err_n   += int'(ErrorProtocolo);
      busy_n  += int'(Ocupado);
      if (Listo) begin
        listo_n++;
        if (listo_at < 0) listo_at = k;
      end
      if (!Ocupado) done = 1'b1;
    end
    chk("cmd_done", {31'b0, done}, 32'd1);
    @(posedge Reloj);
    #1;
  endtask

  function automatic logic [15:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return 16'($urandom_range(0, 31));
  endfunction

  initial begin
    int lee_n, esc_n, listo_n, listo_at, err_n, busy_n, idle_at;
    for (int i = 0; i < 65536; i++) begin
      mem_arr[i] = 16'($urandom);
      ref_mem[i] = mem_arr[i];
    end

    // Reset state
    do_reset();
    chk("rst_datoleido", {16'b0, DatoLeido}, 32'd0);
    chk("rst_listo", {31'b0, Listo}, 32'd0);
    chk("rst_ocupado", {31'b0, Ocupado}, 32'd0);
    chk("rst_error", {31'b0, ErrorProtocolo}, 32'd0);
    chk("rst_memdir", {16'b0, mem_bus.MemDir}, 32'd0);
    chk("rst_memdatosal", {16'b0, mem_bus.MemDatoSal}, 32'd0);
    chk("rst_req", {30'b0, mem_bus.MemLee, mem_bus.MemEscribe}, 32'd0);

    // Fetch with two memory wait cycles
    mem_arr[16'h0040] = 16'hA5C3;
    ref_mem[16'h0040] = 16'hA5C3;
    nwait = 2;
    run_cmd(CMD_FETCH, 16'h0040, 16'h0200, 16'h0000, lee_n, esc_n, listo_n, listo_at, err_n, busy_n);
    chk("fetch_lee_cycles", lee_n, 3);
    chk("fetch_listo_count", listo_n, 1);
    chk("fetch_listo_at", listo_at, 4);
    chk("fetch_dato", {16'b0, DatoLeido}, 32'hA5C3);
    chk("fetch_dir", {16'b0, mem_bus.MemDir}, 32'h0040);

    // Zero-wait write from AR with fresh data
    nwait = 0;
    run_cmd(6'b001011, 16'h0040, 16'h0100, 16'h1234, lee_n, esc_n, listo_n, listo_at, err_n, busy_n);
    chk("wr_esc_cycles", esc_n, 1);
    chk("wr_listo_at", listo_at, 2);
    chk("wr_listo_count", listo_n, 1);
    chk("wr_datosal", {16'b0, mem_bus.MemDatoSal}, 32'h1234);
    chk("wr_dir", {16'b0, mem_bus.MemDir}, 32'h0100);
    chk("wr_mem", {16'b0, mem_arr[16'h0100]}, 32'h1234);

    // Read and write requested together
    run_cmd(6'b101000, 16'h0011, 16'h0022, 16'h0000, lee_n, esc_n, listo_n, listo_at, err_n, busy_n);
    chk("ill_err", err_n, 1);
    chk("ill_lee", lee_n, 0);
    chk("ill_esc", esc_n, 0);
    chk("ill_busy", busy_n, 0);
    chk("ill_listo", listo_n, 0);

    // Ack held high: ignored in REPOSO, then stretches COMPLETO for 3 cycles
    hold_ack = 1'b1;
    repeat (2) @(posedge Reloj);
    #1;
    chk("ack_idle_busy", {31'b0, Ocupado}, 32'd0);
    Control = CMD_FETCH; PC = 16'h0007;
    model_push(CMD_FETCH, 16'h0007, AR, DatoEscritura);
    @(posedge Reloj);
    #1 Control = 6'b100010; AR = 16'h0009;
    lee_n = 0; listo_n = 0; busy_n = 0; idle_at = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Reloj);
      lee_n   += int'(mem_bus.MemLee);
      listo_n += int'(Listo);
      busy_n  += int'(Ocupado);
      if (!Ocupado && idle_at < 0) idle_at = k;
      if (k == 4) begin
        @(posedge Reloj);
        #1 hold_ack = 1'b0; Control = '0;
      end
    end
    chk("hold_idle_at", idle_at, 6);
    chk("hold_listo_count", listo_n, 1);
    chk("hold_lee_cycles", lee_n, 1);
    chk("hold_busy_cycles", busy_n, 5);
    @(posedge Reloj);
    #1;

    // Reset in the middle of a long read
    nwait = 1000;
    Control = 6'b100010; AR = 16'h0033;
    model_push(6'b100010, PC, 16'h0033, DatoEscritura);
    @(posedge Reloj);
    #1 Control = '0;
    @(posedge Reloj);
    #1;
    chk("midrd_lee_before", {31'b0, mem_bus.MemLee}, 32'd1);
    Reiniciar = 1'b1;
    @(posedge Reloj);
    #1;
    chk("midrd_lee", {31'b0, mem_bus.MemLee}, 32'd0);
    chk("midrd_dato", {16'b0, DatoLeido}, 32'd0);
    chk("midrd_ocupado", {31'b0, Ocupado}, 32'd0);
    chk("midrd_datosal", {16'b0, mem_bus.MemDatoSal}, 32'd0);
    Reiniciar  = 1'b0;
    sb.delete();
    m_dato_sal = '0;
    obs_valid  = 1'b0;
    nwait      = 0;
    listo_n    = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge Reloj);
      listo_n += int'(Listo);
    end
    chk("midrd_no_listo", listo_n, 0);
    @(posedge Reloj);
    #1;

    // Random commands, checked by the scoreboard monitor
    for (int i = 0; i < 200; i++) begin
      nwait = $urandom_range(0, 3);
      run_cmd(6'($urandom), rnd_addr(), rnd_addr(), 16'($urandom),
              lee_n, esc_n, listo_n, listo_at, err_n, busy_n);
    end

    repeat (3) @(posedge Reloj);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end
endmodule

// File: doc/interfaz_bus_memoria.md
Name: interfaz_bus_memoria

Overview:
- Memory bus interface directly downstream of the control unit.
- Consumes the 6-bit Control word, the PC and AR address sources, and the register-file write data.
- Runs a 4-phase request/acknowledge handshake with external instruction/data memory.
- Returns the read word for the IR/DR load paths and signals completion and busy back to the control unit.

Parameters:
- ANCHO_DATOS, 16, width of data bus and read/write words
- ANCHO_DIR, 16, width of memory address
- CICLOS_LIMITE, 255, max wait cycles for MemAck before timeout (used only with the optional feature)

Ports:
- Reloj  in  1  system clock, rising edge
- Reiniciar  in  1  synchronous, active-high reset
- Control  in  6  command word: [5] read, [4] reserved (ignored), [3] write, [2] address from PC, [1] address from AR, [0] latch write data
- PC  in  ANCHO_DIR  program counter address
- AR  in  ANCHO_DIR  address register
- DatoEscritura  in  ANCHO_DATOS  write data (register-file port A path)
- DatoLeido  out  ANCHO_DATOS  last word read, held until next read completes
- Listo  out  1  one-cycle completion pulse
- Ocupado  out  1  transaction in progress
- ErrorProtocolo  out  1  one-cycle pulse on illegal command
- MemDir  out  ANCHO_DIR  memory address
- MemDatoSal  out  ANCHO_DATOS  memory write data
- MemDatoEnt  in  ANCHO_DATOS  memory read data
- MemLee  out  1  read request
- MemEscribe  out  1  write request
- MemAck  in  1  memory acknowledge

Behaviour:
- Clock and reset: one clock, Reloj; reset Reiniciar is synchronous and active-high.
- Reset values: state REPOSO; all outputs 0, including DatoLeido, MemDir and MemDatoSal.
- Undriven Control lines resolve to 0 at top level (bus keeper); the block decodes with plain ==.
- States: REPOSO, LECTURA, ESCRITURA, COMPLETO.
- REPOSO, Control[5]=1 and Control[3]=0: accept read.
  - Latch MemDir = PC if Control[2], else AR if Control[1], else 0. PC has priority when both are set.
  - Next state LECTURA.
- REPOSO, Control[3]=1 and Control[5]=0: accept write.
  - Latch address as for a read.
  - Latch MemDatoSal = DatoEscritura if Control[0]=1; otherwise keep the previous MemDatoSal.
  - Next state ESCRITURA.
- REPOSO, Control[5] and Control[3] both 1: no transaction; ErrorProtocolo=1 for one cycle; stay in REPOSO.
- LECTURA: MemLee=1 with MemDir stable. On MemAck sampled 1: DatoLeido <= MemDatoEnt, MemLee <= 0, next state COMPLETO.
- ESCRITURA: MemEscribe=1 with MemDir and MemDatoSal stable. On MemAck=1: MemEscribe <= 0, next state COMPLETO.
- COMPLETO:
  - Listo=1 for exactly one cycle, on entry only.
  - Stay in COMPLETO until MemAck=0 (4-phase return-to-zero), then go to REPOSO.
  - If MemAck is already 0 on entry, return to REPOSO the next cycle.
- Ocupado = (state != REPOSO).
- Control while Ocupado=1 is ignored. No queueing; the control unit re-issues after Listo.
- Latency with zero-wait memory (ack combinational on request):
  - accept at edge T; MemLee high after T; ack sampled at T+1; Listo high after T+1.
  - Minimum is 2 cycles from command to Listo; each memory wait cycle adds one.
- Reset mid-transaction: MemLee/MemEscribe drop at the reset edge and the state returns to REPOSO. DatoLeido is cleared; no Listo pulse.
- MemAck=1 while in REPOSO is ignored.
- No arithmetic. Address and data widths pass through unchanged; no wrap handling is needed.

Optional Feature:
- Macro: TIEMPO_LIMITE_EN.
- When defined:
  - A wait counter clears on entry to LECTURA/ESCRITURA and increments each cycle MemAck=0.
  - On reaching CICLOS_LIMITE: drop the request, ErrorProtocolo=1 for one cycle, Listo=0, DatoLeido unchanged, return to REPOSO.
  - Counter width is clog2(CICLOS_LIMITE+1).
- When undefined: no counter; the block waits indefinitely for MemAck.

Decomposition:
- Shared package (paquete_cpu):
  - state enum for the bus FSM
  - Control bit index constants (CTRL_LEE=5, CTRL_ESCRIBE=3, CTRL_DIR_PC=2, CTRL_DIR_AR=1, CTRL_DATO=0)
  - fetch command constant 6'b100100
- Sub-module: contador_limite (wait-cycle counter with clear/enable/terminal flag), instantiated only under TIEMPO_LIMITE_EN.

Test Plan:
- Fetch: Control=6'b100100, PC=16'h0040, memory acks after 2 waits with 16'hA5C3 -> MemDir=16'h0040, MemLee high 3 cycles, DatoLeido=16'hA5C3, one Listo pulse.
- Write: Control=6'b001011, AR=16'h0100, DatoEscritura=16'h1234, zero-wait ack -> MemEscribe=1 for 1 cycle, MemDatoSal=16'h1234, Listo 2 cycles after command.
- Illegal: Control=6'b101000 in REPOSO -> ErrorProtocolo one pulse, MemLee=MemEscribe=0, Ocupado=0.
- Busy/4-phase: new read issued during COMPLETO while MemAck held high 3 cycles -> command ignored, REPOSO only after MemAck=0, single Listo.
- Reset mid-read: Reiniciar asserted in LECTURA -> next edge MemLee=0, DatoLeido=0, Ocupado=0, no Listo.
- TIEMPO_LIMITE_EN, CICLOS_LIMITE=4, MemAck stuck 0 -> request drops after 4 wait cycles, ErrorProtocolo pulse, Listo never asserted.
